alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Command-queue controller in front of the 8-bit combinational ALU.
- Buffers operation commands (operands, select, shift) in a small FIFO and drives the ALU inputs one command at a time, holding them for a settle window.
- Captures Y and the zero/carry/overflow flags into a result register and hands it off through a valid/ready port.
- Supports chaining: a command may take the previous result as operand A, so multi-step calculations run without reloading from the switches.

Parameters:
WIDTH, 8, operand/result width
DEPTH, 4, command FIFO depth (power of 2, >=2)
SETTLE, 1, cycles ALU inputs are held before capture (>=0)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
flush  in  1  synchronous; empties FIFO, aborts current op
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (count < DEPTH)
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_op  in  3  ALU select S
cmd_shift  in  4  ALU shift amount
cmd_chain  in  1  1: use last result as A, ignore cmd_a
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_s  out  3  to ALU S
alu_shift  out  4  to ALU Shift
alu_y  in  WIDTH  ALU result
alu_zero  in  1  ALU zero flag
alu_carry  in  1  ALU carry flag
alu_overflow  in  1  ALU overflow flag
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_y  out  WIDTH  captured result
res_flags  out  3  captured {overflow, carry, zero}
busy  out  1  state != IDLE or FIFO non-empty
queue_count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied; queue_count=0; cmd_ready=1.
  - State IDLE; all alu_* outputs 0.
  - res_valid=0, res_y=0, res_flags=0; last_y=0; busy=0.
- Push: on an edge with cmd_valid && cmd_ready, store {a,b,op,shift,chain}.
  - cmd_ready depends on count only: no push while full, even in a pop cycle.
- FSM states IDLE, DRIVE, WAIT_OUT.
- IDLE:
  - If FIFO non-empty at an edge: pop the head entry.
  - Load alu_a = chain ? last_y : a. The chain value is resolved at pop time.
  - Load alu_b, alu_s, alu_shift from the entry; cnt=SETTLE; go to DRIVE.
- DRIVE:
  - alu_* stay stable.
  - At each edge: if cnt!=0, cnt-=1.
  - If cnt==0: res_y<=alu_y, res_flags<={alu_overflow,alu_carry,alu_zero}, last_y<=alu_y, res_valid<=1; go to WAIT_OUT.
- WAIT_OUT:
  - Hold res_* and alu_*.
  - At an edge with res_ready=1: res_valid<=0; go to IDLE.
  - The next pop happens at the following edge, at the earliest.
- Latency: command accepted at edge E0 on an idle, empty queue → res_valid rises at edge E0+2+SETTLE. Throughput is one result per SETTLE+3 cycles with res_ready tied high.
- alu_* outputs hold the last driven values in IDLE; there is no return to 0.
- res_y and res_flags are stable while res_valid=1 and remain unchanged after the handshake.
- Pop and push in the same cycle: both happen; count unchanged.
- Wrap-around: read/write pointers wrap modulo DEPTH. Ordering is strict FIFO.
- flush=1 at an edge:
  - Empties FIFO, state IDLE, res_valid<=0.
  - last_y, res_y, res_flags and alu_* are kept.
  - flush has priority over push, pop and capture in the same cycle.
- Async reset mid-DRIVE or mid-WAIT_OUT: everything returns to reset values immediately. No result is emitted.
- busy = (state!=IDLE) || (count!=0).

Test Plan:
- Reset, then push {a=8'h12, b=8'h34, op=000, chain=0} at E0. Bench ALU model for op 000 is Y=A+B. Required: res_valid at E3 (SETTLE=1), res_y=8'h46, res_flags=000; alu_a=8'h12 during DRIVE.
- Chain: push {8'hF0, 8'h20, 000, chain=0} then {xx, 8'h01, 000, chain=1}, res_ready=1. Required: res_y 8'h10 with carry=1, then 8'h11 with res_flags=000; second alu_a=8'h10.
- Full FIFO: hold res_ready=0, push 6 commands back-to-back. Required: cmd_ready=0 once queue_count=4; exactly 5 accepted (1 in flight + 4 queued). Draining with res_ready=1 returns results in push order.
- Backpressure: keep res_ready=0 for 10 cycles after res_valid. Required: res_y/res_flags constant; no new pop; busy=1. Release → res_valid drops next edge; next op pops one edge later.
- Flush with 3 queued and one in DRIVE. Required: next edge queue_count=0, res_valid=0, state IDLE. Then a chain command uses last_y from before the flush.
- Assert rst=0 asynchronously mid-WAIT_OUT. Required: res_valid=0, alu_*=0, cmd_ready=1, last_y=0 without waiting for a clock. A subsequent chain command uses A=0.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: command FIFO that feeds an external combinational ALU one operation at a time
// and returns each captured result and its flags through a valid/ready port.
module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [WIDTH-1:0]             cmd_a,
  input  logic [WIDTH-1:0]             cmd_b,
  input  logic [2:0]                   cmd_op,
  input  logic [3:0]                   cmd_shift,
  input  logic                         cmd_chain,
  output logic [WIDTH-1:0]             alu_a,
  output logic [WIDTH-1:0]             alu_b,
  output logic [2:0]                   alu_s,
  output logic [3:0]                   alu_shift,
  input  logic [WIDTH-1:0]             alu_y,
  input  logic                         alu_zero,
  input  logic                         alu_carry,
  input  logic                         alu_overflow,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [WIDTH-1:0]             res_y,
  output logic [2:0]                   res_flags,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = SETTLE > 0 ? $clog2(SETTLE+1) : 1;
  localparam int EW = 2*WIDTH+8;
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT_OUT} state_t;
  state_t state, state_next;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SW-1:0] cnt;
  logic [WIDTH-1:0] last_y, head_a, head_b;
  logic [2:0] head_op;
  logic [3:0] head_shift;
  logic head_chain, push, pop, capture, handoff;
  assign {head_a, head_b, head_op, head_shift, head_chain} = mem[rd_ptr];
  assign cmd_ready = queue_count != CW'(DEPTH);
  assign busy = state != IDLE || queue_count != '0;
  assign push = cmd_valid && cmd_ready && !flush;
  assign pop = state == IDLE && queue_count != '0 && !flush;
  assign capture = state == DRIVE && cnt == '0 && !flush;
  assign handoff = state == WAIT_OUT && res_ready && !flush;
  always_comb begin
    state_next = flush ? IDLE : pop ? DRIVE : capture ? WAIT_OUT : handoff ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op, cmd_shift, cmd_chain};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_s       <= '0;
      alu_shift   <= '0;
      res_valid   <= 1'b0;
      res_y       <= '0;
      res_flags   <= '0;
      last_y      <= '0;
    end else begin
      state       <= state_next;
      wr_ptr      <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr      <= flush ? '0 : rd_ptr + AW'(pop);
      queue_count <= flush ? '0 : queue_count + CW'(push) - CW'(pop);
      // chain operand is resolved here, at pop time, from the most recent capture
      if (pop) begin
        alu_a     <= head_chain ? last_y : head_a;
        alu_b     <= head_b;
        alu_s     <= head_op;
        alu_shift <= head_shift;
        cnt       <= SW'(SETTLE);
      end else if (state == DRIVE && cnt != '0) begin
        cnt <= cnt - SW'(1);
      end
      if (capture) begin
        res_y     <= alu_y;
        res_flags <= {alu_overflow, alu_carry, alu_zero};
        last_y    <= alu_y;
      end
      res_valid <= flush ? 1'b0 : capture ? 1'b1 : handoff ? 1'b0 : res_valid;
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random stimulus; a queue of expected results built at push time
// is checked by an independent monitor whenever a new result is presented.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst, flush, cmd_valid, cmd_ready, cmd_chain;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, res_y;
  logic [2:0] cmd_op, alu_s, res_flags, queue_count;
  logic [3:0] cmd_shift, alu_shift;
  logic alu_zero, alu_carry, alu_overflow, res_valid, res_ready, busy;
  int vectors = 0, miscompares = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_exp = '0;
  logic [7:0] model_last = '0, mon_last = '0;
  logic prev_rv = 1'b0;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_shift(cmd_shift), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_shift(alu_shift),
    .alu_y(alu_y), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_flags(res_flags),
    .busy(busy), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  // returns {overflow, carry, zero, y}
  function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] s, input logic [3:0] sh);
    logic [8:0] r;
    logic ov;
    ov = 1'b0;
    case (s)
      3'd0: begin r = {1'b0, a} + {1'b0, b}; ov = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin r = {1'b0, a} - {1'b0, b}; ov = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, 8'(a << sh)};
      3'd6: r = {1'b0, 8'(a >> sh)};
      default: r = {1'b0, ~a};
    endcase
    return {ov, r[8], r[7:0] == 8'd0, r[7:0]};
  endfunction

  assign {alu_overflow, alu_carry, alu_zero, alu_y} = alu_f(alu_a, alu_b, alu_s, alu_shift);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (res_valid && !prev_rv) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL result_unexpected: got %0h expected none at %0t", {res_flags, res_y}, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", 32'({res_flags, res_y}), 32'(mon_exp));
        mon_last = mon_exp[7:0];
      end
    end
    prev_rv = res_valid;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [3:0] sh, input logic ch, output logic acc);
    logic [10:0] y;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_shift = sh; cmd_chain = ch; cmd_valid = 1'b1;
    acc = cmd_ready && !flush;
    if (acc) begin
      y = alu_f(ch ? model_last : a, b, op, sh);
      exp_q.push_back(y);
      model_last = y[7:0];
    end
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic push_rand(output logic acc);
    push(8'($urandom), 8'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), acc);
  endtask

  task automatic do_flush_model();
    exp_q.delete();
    model_last = mon_last;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || res_valid) && n < 300) begin cyc(); n++; end
    check("idle_timeout", 32'(busy || res_valid), 32'(0));
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 50) begin cyc(); n++; end
    check("res_timeout", 32'(res_valid), 32'(1));
  endtask

  initial begin
    logic acc;
    int n;
    rst = 1'b0; flush = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_shift = '0; cmd_chain = 1'b0;
    repeat (2) cyc();
    check("rst_state", 32'({queue_count, cmd_ready, res_valid, busy}), 32'({3'd0, 3'b100}));
    check("rst_alu", 32'({alu_a, alu_b, alu_s, alu_shift}), 32'(0));
    check("rst_res", 32'({res_flags, res_y}), 32'(0));
    rst = 1'b1;
    cyc();
    // single add: latency and operand hold
    push(8'h12, 8'h34, 3'd0, 4'd0, 1'b0, acc);
    cyc();
    check("t1_drive_a", 32'(alu_a), 32'h12);
    check("t1_rv_e1", 32'(res_valid), 32'(0));
    cyc();
    check("t1_rv_e2", 32'(res_valid), 32'(0));
    cyc();
    check("t1_rv_e3", 32'(res_valid), 32'(1));
    check("t1_res", 32'({res_flags, res_y}), 32'({3'b000, 8'h46}));
    wait_idle();
    // chain: F0+20 = 10 carry, then 10+01 = 11
    push(8'hF0, 8'h20, 3'd0, 4'd0, 1'b0, acc);
    push(8'h55, 8'h01, 3'd0, 4'd0, 1'b1, acc);
    wait_idle();
    check("t2_chain_a", 32'({alu_a, alu_b}), 32'({8'h10, 8'h01}));
    check("t2_last", 32'(mon_exp), 32'({3'b000, 8'h11}));
    // full FIFO under backpressure
    res_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin push_rand(acc); n += int'(acc); end
    check("t3_accepted", 32'(n), 32'(5));
    check("t3_full", 32'({queue_count, cmd_ready, busy, res_valid}), 32'({3'd4, 3'b011}));
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("t3_hold", 32'({busy, res_valid, queue_count, res_flags, res_y}), 32'({2'b11, 3'd4, mon_exp}));
    end
    res_ready = 1'b1;
    cyc();
    check("t3_release", 32'({res_valid, queue_count}), 32'({1'b0, 3'd4}));
    cyc();
    check("t3_next_pop", 32'(queue_count), 32'(3));
    wait_idle();
    // flush with three queued and one driving
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_rand(acc);
    res_ready = 1'b1;
    cyc();
    cyc();
    check("t4_pre", 32'({queue_count, busy, res_valid}), 32'({3'd3, 2'b10}));
    flush = 1'b1;
    do_flush_model();
    cyc();
    flush = 1'b0;
    check("t4_post", 32'({queue_count, busy, res_valid, cmd_ready}), 32'({3'd0, 3'b001}));
    push(8'h77, 8'h03, 3'd0, 4'd0, 1'b1, acc);
    wait_idle();
    check("t4_chain_a", 32'(alu_a), 32'(mon_last - 8'h03));
    // async reset while a result waits
    res_ready = 1'b0;
    push_rand(acc);
    wait_res();
    #2;
    rst = 1'b0;
    #1;
    check("t5_rst_ctl", 32'({res_valid, cmd_ready, busy, queue_count}), 32'({3'b010, 3'd0}));
    check("t5_rst_alu", 32'({alu_a, alu_b, alu_s, alu_shift}), 32'(0));
    check("t5_rst_res", 32'({res_flags, res_y}), 32'(0));
    exp_q.delete();
    model_last = '0;
    mon_last = '0;
    cyc();
    rst = 1'b1;
    res_ready = 1'b1;
    push(8'h99, 8'h05, 3'd0, 4'd0, 1'b1, acc);
    wait_idle();
    check("t5_chain_a", 32'(alu_a), 32'(0));
    // random traffic with backpressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      res_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 39) == 0;
      if (flush) do_flush_model();
      if ($urandom_range(0, 1) != 0) push_rand(acc);
      else cyc();
      flush = 1'b0;
    end
    res_ready = 1'b1;
    wait_idle();
    check("drain_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
